input_debounce: RTL and testbench
=================================

Name: input_debounce

Overview:
- Conditions a raw asynchronous control input into the clean single-bit level consumed by the downstream control FSM in the cell library.
- Synchronises the input into the mclk domain and debounces it with a programmable stable-time counter.
- Produces a debounced level plus one-cycle rise and fall event pulses.
- Sits directly upstream of the state-machine block; db_out drives that block's `a` input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- DB_CYCLES, 16, consecutive identical synchronised samples required to accept a new level (legal range 1..2^CNT_W-1).
- CNT_W, 16, width of the debounce counter.

Ports:
- mclk  input  1  sole clock, rising edge.
- mreset  input  1  synchronous active-high reset.
- en  input  1  debounce enable; when 0 the accepted level is frozen.
- raw_in  input  1  raw asynchronous input.
- db_out  output  1  debounced level, registered.
- rise_pulse  output  1  one-cycle pulse on accepted 0->1.
- fall_pulse  output  1  one-cycle pulse on accepted 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Clock and reset (decided): one clock, mclk. Reset mreset is synchronous and active-high, sampled on the mclk rising edge.
- Reset values: all synchroniser flops 0, state LOW, counter 0, db_out 0, rise_pulse 0, fall_pulse 0, busy 0. Reset mid-qualification aborts with no pulse.
- Synchroniser: raw_in passes through a SYNC_STAGES flop chain. The last stage is s. Only s is used downstream.
- FSM states: LOW, CHK_HI, HIGH, CHK_LO. db_out=1 in HIGH and CHK_LO, 0 otherwise. busy=1 in CHK_HI and CHK_LO.
- LOW: s=1 and en=1 -> CHK_HI, cnt<=1. If DB_CYCLES=1, go directly to HIGH with rise_pulse.
- CHK_HI:
  - s=0 -> LOW, cnt<=0 (glitch).
  - s=1 and cnt==DB_CYCLES-1 -> HIGH, cnt<=0, rise_pulse<=1.
  - otherwise cnt<=cnt+1.
- HIGH and CHK_LO: mirror of LOW and CHK_HI with polarity inverted; acceptance produces fall_pulse.
- en=0: CHK_HI returns to LOW and CHK_LO returns to HIGH, cnt<=0, no pulses. LOW and HIGH hold. The synchroniser keeps running.
- Latency: edge 0 is the first edge at which raw_in is captured high (held stable). db_out and rise_pulse go high after edge SYNC_STAGES+DB_CYCLES-1. Same latency applies to falling transitions.
- Pulses are registered and high for exactly one cycle. rise_pulse and fall_pulse are never high together.
- The counter never wraps: it is bounded by DB_CYCLES-1.
- raw_in high when reset releases: treated as a normal 0->1 transition; rise_pulse fires after the standard latency.

Optional Feature:
- Macro: INPUT_DEBOUNCE_GLITCH_CNT_EN.
- Defined: adds output port glitch_cnt (16 bits).
  - Reset to 0.
  - Increments by 1 each time CHK_HI or CHK_LO aborts because s reverts.
  - Saturates at 16'hFFFF.
  - Aborts caused by en=0 are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults changed to SYNC_STAGES=2, DB_CYCLES=4. raw_in 0->1 held, first captured at edge 0 -> db_out=1 and rise_pulse=1 after edge 5 only; busy high after edges 2..4.
- Same configuration. raw_in high for 2 cycles then low -> db_out stays 0, no pulses, glitch_cnt=1 (macro defined).
- db_out=1, raw_in falls and is held -> fall_pulse single cycle after edge 5, db_out=0.
- mreset asserted for one cycle while in CHK_HI -> next cycle: state LOW, db_out=0, busy=0, no rise_pulse; debounce restarts if raw_in is still high.
- en=0 during CHK_HI with raw_in held high -> state returns to LOW and db_out stays 0. en=1 again -> full DB_CYCLES requalification, then rise_pulse.
- DB_CYCLES=1, raw_in toggles every 3 cycles -> db_out follows s with 1-cycle delay; one rise or fall pulse per toggle.

Source files
------------

// File: rtl/input_debounce.sv
// Synchronises and debounces a raw asynchronous input into a clean level with rise/fall event pulses.
// Optional abort counter output glitch_cnt is enabled by defining INPUT_DEBOUNCE_GLITCH_CNT_EN.
module input_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        mclk,
    input  logic        mreset,
    input  logic        en,
    input  logic        raw_in,
    output logic        db_out,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        busy
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [15:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    // Last qualification count before a candidate level is accepted.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam bit               DB_ONE  = (DB_CYCLES == 32'd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   rise_nxt_s;
    logic                   fall_nxt_s;

    assign s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain; keeps running regardless of en.
    always_ff @(posedge mclk) begin
        if (mreset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge mclk) begin
        if (mreset) begin
            state_r    <= LOW;
            cnt_r      <= '0;
            db_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            db_out     <= (state_nxt_s == HIGH) || (state_nxt_s == CHK_LO);
            rise_pulse <= rise_nxt_s;
            fall_pulse <= fall_nxt_s;
            busy       <= (state_nxt_s == CHK_HI) || (state_nxt_s == CHK_LO);
        end
    end

    // Next-state, counter and pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        case (state_r)
            LOW: begin
                if (en && s) begin
                    if (DB_ONE) begin
                        state_nxt_s = HIGH;
                        cnt_nxt_s   = '0;
                        rise_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = CHK_HI;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    state_nxt_s = LOW;
                end
            end
            CHK_HI: begin
                if (!en || !s) begin
                    state_nxt_s = LOW;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == DB_LAST) begin
                    state_nxt_s = HIGH;
                    cnt_nxt_s   = '0;
                    rise_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            HIGH: begin
                if (en && !s) begin
                    if (DB_ONE) begin
                        state_nxt_s = LOW;
                        cnt_nxt_s   = '0;
                        fall_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = CHK_LO;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    state_nxt_s = HIGH;
                end
            end
            CHK_LO: begin
                if (!en || s) begin
                    state_nxt_s = HIGH;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == DB_LAST) begin
                    state_nxt_s = LOW;
                    cnt_nxt_s   = '0;
                    fall_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = LOW;
                cnt_nxt_s   = '0;
            end
        endcase
    end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic glitch_s;

    // Only reversions of s abort-count; en=0 aborts are deliberately excluded.
    assign glitch_s = en && (((state_r == CHK_HI) && !s) || ((state_r == CHK_LO) && s));

    // Saturating abort counter.
    always_ff @(posedge mclk) begin
        if (mreset) begin
            glitch_cnt <= 16'h0000;
        end else if (glitch_s && (glitch_cnt != 16'hFFFF)) begin
            glitch_cnt <= glitch_cnt + 16'h0001;
        end else begin
            glitch_cnt <= glitch_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: SYNC_STAGES=2/DB_CYCLES=4 main instance plus a DB_CYCLES=1 instance.
module tb_input_debounce;

    logic mclk;
    logic mreset;
    logic en;
    logic raw_in;
    logic raw1;
    logic db_out, rise_pulse, fall_pulse, busy;
    logic db_out1, rise_pulse1, fall_pulse1, busy1;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic [15:0] glitch_cnt;
    logic [15:0] glitch_cnt1;
`endif

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned exp_glitch;
    logic [3:0]  sb_q[$];
    logic [3:0]  sb1_q[$];

    input_debounce #(.SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(16)) dut (
        .mclk(mclk), .mreset(mreset), .en(en), .raw_in(raw_in),
        .db_out(db_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(glitch_cnt)
`endif
    );

    input_debounce #(.SYNC_STAGES(2), .DB_CYCLES(1), .CNT_W(16)) dut1 (
        .mclk(mclk), .mreset(mreset), .en(en), .raw_in(raw1),
        .db_out(db_out1), .rise_pulse(rise_pulse1), .fall_pulse(fall_pulse1), .busy(busy1)
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(glitch_cnt1)
`endif
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Vectors are {db_out, rise_pulse, fall_pulse, busy}, sampled 1 time unit after each edge.
    task automatic test_reset();
        logic [3:0] obs;
        mreset = 1'b1; en = 1'b1; raw_in = 1'b0; raw1 = 1'b0;
        exp_glitch = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge mclk); #1;
            obs = {db_out, rise_pulse, fall_pulse, busy};
            n_cmp++;
            if (obs !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_state cycle %0d: got %b expected %b", i, obs, 4'b0000);
            end
        end
        mreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge mclk); #1;
            obs = {db_out, rise_pulse, fall_pulse, busy};
            n_cmp++;
            if (obs !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs, 4'b0000);
            end
        end
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_glitch_cnt: got %0d expected 0", glitch_cnt);
        end
`endif
    endtask

    task automatic test_rise();
        logic [3:0] obs, exp;
        logic [3:0] seq [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                4'b1100, 4'b1000, 4'b1000};
        for (int i = 0; i < 8; i++) sb_q.push_back(seq[i]);
        raw_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge mclk); #1;
            obs = {db_out, rise_pulse, fall_pulse, busy};
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rise edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_fall();
        logic [3:0] obs, exp;
        logic [3:0] seq [8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001,
                                4'b0010, 4'b0000, 4'b0000};
        for (int i = 0; i < 8; i++) sb_q.push_back(seq[i]);
        raw_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge mclk); #1;
            obs = {db_out, rise_pulse, fall_pulse, busy};
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL fall edge %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] obs, exp;
        logic [3:0] seq [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 8; i++) sb_q.push_back(seq[i]);
        exp_glitch = exp_glitch + 1;
        raw_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge mclk); #1;
            obs = {db_out, rise_pulse, fall_pulse, busy};
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL glitch edge %0d: got %b expected %b", i, obs, exp);
            end
            if (i == 1) raw_in = 1'b0;
        end
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== 16'(exp_glitch)) begin
            n_bad++;
            $display("FAIL glitch_cnt: got %0d expected %0d", glitch_cnt, exp_glitch);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        logic [3:0] seq [11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
        for (int i = 0; i < 11; i++) sb_q.push_back(seq[i]);
        raw_in = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge mclk); #1;
            obs = {db_out, rise_pulse, fall_pulse, busy};
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_mid edge %0d: got %b expected %b", i, obs, exp);
            end
            if (i == 2) mreset = 1'b1;
            if (i == 3) mreset = 1'b0;
        end
        exp_glitch = 0;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== 16'(exp_glitch)) begin
            n_bad++;
            $display("FAIL reset_mid_glitch_cnt: got %0d expected %0d", glitch_cnt, exp_glitch);
        end
`endif
    endtask

    task automatic test_enable();
        logic [3:0] obs, exp;
        logic [3:0] seq [11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
        for (int i = 0; i < 11; i++) sb_q.push_back(seq[i]);
        raw_in = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge mclk); #1;
            obs = {db_out, rise_pulse, fall_pulse, busy};
            exp = sb_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL enable edge %0d: got %b expected %b", i, obs, exp);
            end
            if (i == 3) en = 1'b0;
            if (i == 5) en = 1'b1;
        end
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== 16'(exp_glitch)) begin
            n_bad++;
            $display("FAIL enable_glitch_cnt: got %0d expected %0d", glitch_cnt, exp_glitch);
        end
`endif
    endtask

    // Expected level for edge k+2 is pushed as raw1 is driven for edge k.
    task automatic test_db_one();
        logic [3:0] obs, exp;
        logic       prev;
        prev = 1'b0;
        sb1_q.push_back(4'b0000);
        sb1_q.push_back(4'b0000);
        for (int k = 0; k < 20; k++) begin
            raw1 = (((k / 3) % 2) == 0) ? 1'b1 : 1'b0;
            sb1_q.push_back({raw1, raw1 & ~prev, ~raw1 & prev, 1'b0});
            prev = raw1;
            @(posedge mclk); #1;
            obs = {db_out1, rise_pulse1, fall_pulse1, busy1};
            exp = sb1_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL db_one edge %0d: got %b expected %b", k, obs, exp);
            end
        end
        while (sb1_q.size() > 0) begin
            @(posedge mclk); #1;
            obs = {db_out1, rise_pulse1, fall_pulse1, busy1};
            exp = sb1_q.pop_front();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL db_one drain: got %b expected %b", obs, exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mreset = 1'b1; en = 1'b1; raw_in = 1'b0; raw1 = 1'b0;
        #1;
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_reset_mid();
        test_fall();
        test_enable();
        test_db_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
